reg18_load_arbiter: RTL and testbench

Round-robin controller that shares one 18-bit two-enable holding register (reset active-high, loads when ce1 & ce2) among NUM_REQ producers.
- Selects a requester and steers its data onto the register input.
- Drives both clock enables and the register's clear.
- Tracks register occupancy with a valid/ready handshake to a single consumer.
- Sits between the request-side producers and the downstream consumer of the held word.

---
 rtl/reg18_load_arbiter.sv | 115 +++++++++++
 tb/tb_reg18_load_arbiter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/reg18_load_arbiter.sv
// Round-robin load controller for a shared two-enable holding register with a valid/ready consumer side.
// Optional watchdog on an unconsumed word: define REG18_ARB_TIMEOUT_EN.
module reg18_load_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int WIDTH          = 18,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [WIDTH-1:0]         reg_in,
  output logic                     reg_ce1,
  output logic                     reg_ce2,
  output logic                     reg_clr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     timeout_err
);

  localparam int PTR_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("reg18_load_arbiter: unsupported parameter set");
  end

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [PTR_W-1:0] rr_ptr, rr_ptr_nxt, winner, sel;
  logic             consume, slot_free, grant, wd_fire;

  // First set request at or above rr_ptr, wrapping around.
  always_comb begin
    int               idx;
    logic             found;
    logic [PTR_W-1:0] idx_v;
    winner = rr_ptr;
    found  = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      idx_v = PTR_W'(idx);
      if (!found && req[idx_v]) begin
        found  = 1'b1;
        winner = idx_v;
      end
    end
  end

  assign consume   = (state == FULL) & out_ready;
  assign slot_free = (state == EMPTY) | consume;
  assign grant     = reset & slot_free & (|req) & ~wd_fire;
  assign sel       = grant ? winner : rr_ptr;

  assign gnt       = grant ? (NUM_REQ'(1) << winner) : '0;
  assign reg_in    = req_data[int'(sel)*WIDTH +: WIDTH];
  assign reg_ce1   = grant;
  assign reg_ce2   = reset & slot_free;
  assign reg_clr   = ~reset | wd_fire;
  assign out_valid = reset & (state == FULL);

  always_comb begin
    state_nxt  = state;
    rr_ptr_nxt = rr_ptr;
    case (state)
      EMPTY: if (grant) state_nxt = FULL;
      FULL: begin
        if (wd_fire)      state_nxt = EMPTY;
        else if (consume) state_nxt = grant ? FULL : EMPTY;
      end
      default: state_nxt = EMPTY;
    endcase
    if (grant) rr_ptr_nxt = (winner == PTR_W'(NUM_REQ-1)) ? '0 : winner + PTR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= EMPTY;
      rr_ptr <= '0;
    end else begin
      state  <= state_nxt;
      rr_ptr <= rr_ptr_nxt;
    end
  end

`ifdef REG18_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CNT_W-1:0] wd_cnt;
  logic             timeout_q;

  // Counts stalled cycles of the current word; a new load or a consume restarts it.
  assign wd_fire = reset & (state == FULL) & ~out_ready &
                   (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (wd_fire || grant || consume) wd_cnt <= '0;
      else if (state == FULL && !out_ready) wd_cnt <= wd_cnt + CNT_W'(1);
      if (wd_fire) timeout_q <= 1'b1;
    end
  end

  assign timeout_err = timeout_q;
`else
  assign wd_fire     = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_reg18_load_arbiter.sv
// Scoreboard bench for reg18_load_arbiter: stimulus queues expected grants/consumed words, a monitor pops and compares.
module tb_reg18_load_arbiter;

  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 18;
  localparam int TO      = 16;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]       gnt;
  logic [WIDTH-1:0]         reg_in;
  logic                     reg_ce1, reg_ce2, reg_clr, out_valid, out_ready, timeout_err;

  logic [WIDTH-1:0] dv [NUM_REQ] = '{18'h00011, 18'h12222, 18'h2ABCD, 18'h3F00F};
  assign req_data = {dv[3], dv[2], dv[1], dv[0]};

  reg18_load_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data), .gnt(gnt), .reg_in(reg_in),
    .reg_ce1(reg_ce1), .reg_ce2(reg_ce2), .reg_clr(reg_clr), .out_valid(out_valid),
    .out_ready(out_ready), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // The external holding register: active-high clear, loads when both enables are set.
  logic [WIDTH-1:0] held;
  always @(posedge clk) begin
    if (reg_clr) held <= '0;
    else if (reg_ce1 & reg_ce2) held <= reg_in;
  end

  int n_checks = 0;
  int n_fail   = 0;

  logic [NUM_REQ-1:0] gq [$];
  logic [WIDTH-1:0]   dq [$];
  logic [WIDTH-1:0]   cq [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic expect_grant(input int i);
    logic [NUM_REQ-1:0] g;
    g = 1;
    g = g << i;
    gq.push_back(g);
    dq.push_back(dv[i]);
    cq.push_back(dv[i]);
  endtask

  task automatic drive(input logic rst_v, input logic [NUM_REQ-1:0] req_v, input logic rdy_v);
    @(posedge clk);
    #1;
    reset     = rst_v;
    req       = req_v;
    out_ready = rdy_v;
  endtask

  // Monitor: grants and consumes are matched in order against the queues.
  initial begin
    forever begin
      @(negedge clk);
      if (|gnt) begin
        if (gq.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_gnt: got %b required none", gnt);
        end else begin
          check("gnt", 32'(gnt), 32'(gq.pop_front()));
          check("reg_in", 32'(reg_in), 32'(dq.pop_front()));
          check("ce1_ce2_on_gnt", 32'({reg_ce1, reg_ce2}), 32'h3);
        end
      end
      if (out_valid & out_ready) begin
        if (cq.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_consume: got %h required none", held);
        end else begin
          check("consumed_word", 32'(held), 32'(cq.pop_front()));
        end
      end
    end
  end

  initial begin
    reset = 1'b0; req = '1; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_clr", 32'(reg_clr), 32'h1);
      check("rst_gnt", 32'(gnt), 32'h0);
      check("rst_ce", 32'({reg_ce1, reg_ce2}), 32'h0);
      check("rst_out_valid", 32'(out_valid), 32'h0);
    end
    drive(1'b1, 4'b0000, 1'b0);
    @(negedge clk);
    check("idle_clr", 32'(reg_clr), 32'h0);
    check("idle_out_valid", 32'(out_valid), 32'h0);
    check("idle_ce2", 32'(reg_ce2), 32'h1);

    // Fairness from pointer 0, back-to-back with a ready consumer.
    drive(1'b1, 4'b1111, 1'b1);
    expect_grant(0); expect_grant(1); expect_grant(2); expect_grant(3); expect_grant(0);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(posedge clk);
      @(negedge clk);
      if (k > 0) check("fair_out_valid", 32'(out_valid), 32'h1);
    end
    drive(1'b1, 4'b0000, 1'b1);
    @(negedge clk);
    check("drain_out_valid", 32'(out_valid), 32'h1);

    // Single requester 2 from EMPTY; out_ready while EMPTY is ignored.
    drive(1'b1, 4'b0100, 1'b1);
    expect_grant(2);
    @(negedge clk);
    check("single_out_valid_before", 32'(out_valid), 32'h0);

    // Stall: FULL, consumer not ready, requester 0 waiting.
    drive(1'b1, 4'b0001, 1'b0);
    for (int k = 0; k < 10; k++) begin
      if (k > 0) @(posedge clk);
      @(negedge clk);
      check("stall_gnt", 32'(gnt), 32'h0);
      check("stall_ce2", 32'(reg_ce2), 32'h0);
      check("stall_out_valid", 32'(out_valid), 32'h1);
    end
    drive(1'b1, 4'b0001, 1'b1);
    expect_grant(0);
    @(negedge clk);
    drive(1'b1, 4'b0000, 1'b0);
    @(negedge clk);
    check("b2b_stays_full", 32'(out_valid), 32'h1);

    // Reset mid-hold discards the pending word.
    drive(1'b0, 4'b1111, 1'b1);
    cq.delete();
    @(negedge clk);
    check("midrst_gnt", 32'(gnt), 32'h0);
    check("midrst_clr", 32'(reg_clr), 32'h1);
    check("midrst_out_valid", 32'(out_valid), 32'h0);
    drive(1'b1, 4'b0000, 1'b0);
    @(negedge clk);
    check("post_rst_out_valid", 32'(out_valid), 32'h0);
    check("held_cleared", 32'(held), 32'h0);

    // Pointer back at 0: req 1001 must pick requester 0.
    drive(1'b1, 4'b1001, 1'b0);
    expect_grant(0);
    @(negedge clk);
    drive(1'b1, 4'b0000, 1'b1);
    @(negedge clk);
    drive(1'b1, 4'b0000, 1'b0);
    @(negedge clk);
    check("empty_again", 32'(out_valid), 32'h0);

`ifdef REG18_ARB_TIMEOUT_EN
    drive(1'b1, 4'b0010, 1'b0);
    expect_grant(1);
    @(negedge clk);
    drive(1'b1, 4'b0000, 1'b0);
    for (int k = 1; k <= TO; k++) begin
      if (k > 1) @(posedge clk);
      @(negedge clk);
      check("wd_clr", 32'(reg_clr), (k == TO) ? 32'h1 : 32'h0);
      check("wd_out_valid", 32'(out_valid), 32'h1);
      check("wd_err_before", 32'(timeout_err), 32'h0);
    end
    cq.delete();
    drive(1'b1, 4'b0000, 1'b1);
    @(negedge clk);
    check("wd_out_valid_after", 32'(out_valid), 32'h0);
    check("wd_err_set", 32'(timeout_err), 32'h1);
    check("wd_held_cleared", 32'(held), 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("wd_err_sticky", 32'(timeout_err), 32'h1);
    drive(1'b0, 4'b0000, 1'b0);
    drive(1'b1, 4'b0000, 1'b0);
    @(negedge clk);
    check("wd_err_cleared", 32'(timeout_err), 32'h0);
`else
    check("timeout_err_tied", 32'(timeout_err), 32'h0);
`endif

    repeat (2) @(negedge clk);
    check("gnt_queue_drained", 32'(gq.size()), 32'h0);
    check("consume_queue_drained", 32'(cq.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
